// File: rtl/instr_mem_fetch.sv
// Synchronous instruction memory with a valid/ready fetch port, a program-load
// write port, alignment/range checking and a saturating fetch-error counter.
module instr_mem_fetch #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DEPTH_WORDS   = 128,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    address,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     resp_err,
    input  logic                     load_en,
    input  logic [ADDR_WIDTH-1:0]    load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic                     load_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] fetch_word;
    logic [ADDR_WIDTH-1:0] load_word;
    logic                  fetch_ok;
    logic                  load_ok;
    logic                  accept;

    // Full-width compare so high address bits never alias into the array.
    assign fetch_word = address >> 2;
    assign load_word  = load_addr >> 2;
    assign fetch_ok   = (address[1:0] == 2'b00) && (fetch_word < DEPTH_A);
    assign load_ok    = (load_addr[1:0] == 2'b00) && (load_word < DEPTH_A);

    assign req_ready = !load_en && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    // Storage is not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            mem[load_word[IDX_W-1:0]] <= load_data;
        end
    end

    // Response register: one-cycle latency, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            data_out   <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= !fetch_ok;
            data_out   <= fetch_ok ? mem[fetch_word[IDX_W-1:0]] : '0;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load_en && !load_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && !fetch_ok && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the memory.
module tb_instr_mem_fetch;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] address = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          resp_err;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          load_err;
    logic [CW-1:0] err_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    instr_mem_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .ERR_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .address(address), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .data_out(data_out), .resp_err(resp_err), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .load_err(load_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Model state: what the outputs must be according to the rules.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_err;
    bit            m_lerr;
    int            m_cnt;

    function automatic bit addr_ok(logic [AW-1:0] a);
        return (a % 4 == 0) && ((a / 4) < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_lerr = 1'b0; m_cnt = 0;
        end else begin
            bit rdy;
            rdy = !load_en && (!m_valid || resp_ready);
            m_lerr = load_en && !addr_ok(load_addr);
            if (load_en && addr_ok(load_addr)) m_mem[load_addr / 4] = load_data;
            if (req_valid && rdy) begin
                m_valid = 1'b1;
                m_err   = !addr_ok(address);
                m_data  = m_err ? '0 : m_mem[address / 4];
                if (m_err && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            end else if (m_valid && resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("req_ready", 64'(req_ready), 64'(!load_en && (!m_valid || resp_ready)));
            check("resp_valid", 64'(resp_valid), 64'(m_valid));
            check("data_out", 64'(data_out), 64'(m_data));
            check("resp_err", 64'(resp_err), 64'(m_err));
            check("load_err", 64'(load_err), 64'(m_lerr));
            check("err_count", 64'(err_count), 64'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        case ($urandom_range(0, 9))
            0: return (AW'($urandom_range(0, DEPTH - 1)) << 2) | AW'($urandom_range(1, 3));
            1: return (AW'($urandom_range(DEPTH, 4000)) << 2);
            2: return AW'($urandom) | 32'h8000_0000;
            default: return AW'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Fill every word so later fetches are defined.
        load_en = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            load_addr = AW'(i) << 2;
            load_data = $urandom;
            cyc();
        end
        load_addr = 0; load_data = 32'h8D10_0200; cyc();
        load_addr = 4; load_data = 32'h0000_0018; cyc();
        load_en = 1'b0;

        // Back-to-back fetches.
        resp_ready = 1'b1; req_valid = 1'b1; address = 0;
        cyc();
        check("fetch0_data", 64'(data_out), 64'h8D10_0200);
        check("fetch0_err", 64'(resp_err), 64'd0);
        address = 4;
        cyc();
        check("fetch4_data", 64'(data_out), 64'h0000_0018);
        check("fetch4_valid", 64'(resp_valid), 64'd1);
        req_valid = 1'b0;
        cyc();

        // Stall with a pending request behind it.
        req_valid = 1'b1; address = 8; resp_ready = 1'b0;
        cyc();
        address = 12;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_data", 64'(data_out), 64'(m_mem[2]));
            cyc();
        end
        resp_ready = 1'b1;
        #1 check("unstall_ready", 64'(req_ready), 64'd1);
        cyc();
        check("fetch12_data", 64'(data_out), 64'(m_mem[3]));
        req_valid = 1'b0;
        cyc();

        // Misaligned and out-of-range fetches.
        check("cnt_before", 64'(err_count), 64'd0);
        req_valid = 1'b1; address = 6;
        cyc();
        check("mis_err", 64'(resp_err), 64'd1);
        check("mis_data", 64'(data_out), 64'd0);
        check("mis_cnt", 64'(err_count), 64'd1);
        address = 4 * DEPTH;
        cyc();
        check("oor_err", 64'(resp_err), 64'd1);
        check("oor_cnt", 64'(err_count), 64'd2);
        req_valid = 1'b0;
        cyc();

        // Rejected load and load priority.
        load_en = 1'b1; load_addr = 2; load_data = 32'hFFFF_FFFF;
        cyc();
        load_en = 1'b0;
        check("lerr_pulse", 64'(load_err), 64'd1);
        cyc();
        check("lerr_clear", 64'(load_err), 64'd0);
        req_valid = 1'b1; address = 0;
        cyc();
        check("unchanged0", 64'(data_out), 64'h8D10_0200);
        load_en = 1'b1; load_addr = 20; load_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1 check("load_blocks_ready", 64'(req_ready), 64'd0);
            cyc();
        end
        load_en = 1'b0;
        address = 20;
        cyc();
        check("raw20", 64'(data_out), 64'h1234_5678);

        // Saturation of the 2-bit counter.
        address = 3;
        cyc();
        check("sat_cnt3", 64'(err_count), 64'd3);
        address = 32'h4000_0000;
        cyc();
        check("sat_hold", 64'(err_count), 64'd3);
        req_valid = 1'b0;
        cyc();

        // Asynchronous reset in the middle of a stall.
        req_valid = 1'b1; address = 0; resp_ready = 1'b0;
        cyc();
        req_valid = 1'b0;
        check("pre_rst_valid", 64'(resp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", 64'(resp_valid), 64'd0);
        check("async_rst_cnt", 64'(err_count), 64'd0);
        cyc();
        rst_n = 1'b1; resp_ready = 1'b1; req_valid = 1'b1; address = 0;
        cyc();
        check("mem_kept", 64'(data_out), 64'h8D10_0200);
        req_valid = 1'b0;
        cyc();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if (n % 75 == 74) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            address    = rnd_addr();
            load_en    = ($urandom_range(0, 4) == 0);
            load_addr  = rnd_addr();
            load_data  = $urandom;
            cyc();
        end
        req_valid = 1'b0; load_en = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
